// File: rtl/getir_pkg.sv
// Shared definitions for the RV32 fetch stage: bubble instruction, realignment
// buffer sizing and the compressed-instruction test also used by the expander.
package getir_pkg;

    localparam logic [31:0] VARSAYILAN_NOP  = 32'h0000_0013;
    localparam int          TAMPON_DERINLIK = 4;
    localparam int          YARIM_SAYI_W    = 3;

    typedef logic [YARIM_SAYI_W-1:0] yarim_sayi_t;

    // A halfword starts a 16-bit instruction unless its two low bits are 2'b11.
    function automatic logic sikistirilmis_mi(input logic [15:0] yarim);
        return yarim[1:0] != 2'b11;
    endfunction

endpackage

// File: rtl/getir_hizalayici.sv
// Four-halfword realignment buffer: appends fetched words (or their upper half),
// presents the oldest instruction with its PC and consumes 1 or 2 halfwords.
module getir_hizalayici
    import getir_pkg::*;
#(
    parameter logic [30:0] BASLANGIC_PS = 31'h2000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        i_temizle,
    input  logic [30:0] i_temizle_ps,
    input  logic        i_ekle,
    input  logic        i_ekle_ust,
    input  logic [31:0] i_kelime,
    input  logic        i_tuket,
    output logic        o_hazir,
    output logic [31:0] o_buyruk,
    output logic [30:0] o_ps,
    output logic [30:0] o_ps_sonraki,
    output yarim_sayi_t o_sayi
);

    logic [15:0] r_yarim [TAMPON_DERINLIK];
    yarim_sayi_t r_sayi;
    logic [30:0] r_ps;

    logic        w_sikistirilmis;
    yarim_sayi_t w_tuketilen;
    yarim_sayi_t w_kalan;
    yarim_sayi_t w_eklenen;
    logic [15:0] w_yarim_sonraki [TAMPON_DERINLIK];

    assign w_sikistirilmis = sikistirilmis_mi(r_yarim[0]);
    assign o_hazir         = ((r_sayi != 3'd0) && w_sikistirilmis) || (r_sayi >= 3'd2);
    assign o_buyruk        = w_sikistirilmis ? {16'h0000, r_yarim[0]} : {r_yarim[1], r_yarim[0]};
    assign o_ps            = r_ps;
    assign o_ps_sonraki    = r_ps + (w_sikistirilmis ? 31'd1 : 31'd2);
    assign o_sayi          = r_sayi;

    assign w_tuketilen = (i_tuket && o_hazir) ? (w_sikistirilmis ? 3'd1 : 3'd2) : 3'd0;
    assign w_kalan     = r_sayi - w_tuketilen;
    assign w_eklenen   = i_ekle ? (i_ekle_ust ? 3'd1 : 3'd2) : 3'd0;

    // Shift out consumed halfwords first, then place the new ones behind the survivors.
    always_comb begin
        for (int i = 0; i < TAMPON_DERINLIK; i++) begin
            w_yarim_sonraki[i] = r_yarim[i];
        end
        case (w_tuketilen)
            3'd1: begin
                for (int i = 0; i < TAMPON_DERINLIK - 1; i++) begin
                    w_yarim_sonraki[i] = r_yarim[i+1];
                end
                w_yarim_sonraki[TAMPON_DERINLIK-1] = '0;
            end
            3'd2: begin
                for (int i = 0; i < TAMPON_DERINLIK - 2; i++) begin
                    w_yarim_sonraki[i] = r_yarim[i+2];
                end
                w_yarim_sonraki[TAMPON_DERINLIK-2] = '0;
                w_yarim_sonraki[TAMPON_DERINLIK-1] = '0;
            end
            default: ;
        endcase
        if (i_ekle) begin
            for (int i = 0; i < TAMPON_DERINLIK; i++) begin
                if (yarim_sayi_t'(i) == w_kalan) begin
                    w_yarim_sonraki[i] = i_ekle_ust ? i_kelime[31:16] : i_kelime[15:0];
                end else if (!i_ekle_ust && (yarim_sayi_t'(i) == w_kalan + 3'd1)) begin
                    w_yarim_sonraki[i] = i_kelime[31:16];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sayi <= '0;
            r_ps   <= BASLANGIC_PS;
            for (int i = 0; i < TAMPON_DERINLIK; i++) begin
                r_yarim[i] <= '0;
            end
        end else if (i_temizle) begin
            r_sayi <= '0;
            r_ps   <= i_temizle_ps;
        end else begin
            r_sayi <= w_kalan + w_eklenen;
            r_ps   <= r_ps + 31'(w_tuketilen);
            for (int i = 0; i < TAMPON_DERINLIK; i++) begin
                r_yarim[i] <= w_yarim_sonraki[i];
            end
        end
    end

endmodule

// File: rtl/getir.sv
// RV32 fetch stage: single-outstanding word requests to L1I, halfword realignment,
// and the output registers feeding decode with redirect/stall/flush handling.
module getir
    import getir_pkg::*;
#(
    parameter logic [31:0] BASLANGIC_PS = 32'h4000_0000,
    parameter logic [31:0] NOP_BUYRUK   = VARSAYILAN_NOP
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic [29:0] l1b_adres_o,
    output logic        l1b_istek_gecerli_o,
    input  logic        l1b_istek_hazir_i,
    input  logic [31:0] l1b_buyruk_i,
    input  logic        l1b_buyruk_gecerli_i,
    input  logic        yrt_atlama_gecerli_i,
    input  logic [30:0] yrt_atlama_ps_i,
    input  logic        ddb_durdur_i,
    input  logic        ddb_bosalt_i,
    output logic [31:0] gtr_buyruk_o,
    output logic [30:0] gtr_ps_o,
    output logic [30:0] gtr_ps_artmis_o,
    output logic        ddb_getir_bos_o
);

    logic [30:0] r_ps_getir;
    logic        r_bekleyen;
    logic        r_ust_yarim;
    logic        r_dusur;
    logic [31:0] r_buyruk;
    logic [30:0] r_ps;
    logic [30:0] r_ps_artmis;
    logic        r_bos;

    logic        w_istek;
    logic        w_kabul;
    logic        w_yanit;
    logic        w_ekle;
    logic        w_ver;
    logic        w_hazir;
    logic [31:0] w_buyruk;
    logic [30:0] w_ps;
    logic [30:0] w_ps_sonraki;
    yarim_sayi_t w_sayi;

    // With at most 2 halfwords held, one outstanding word can never overflow the buffer.
    assign w_istek = !rst_i && !r_bekleyen && (w_sayi <= 3'd2);
    assign w_kabul = w_istek && l1b_istek_hazir_i;
    assign w_yanit = l1b_buyruk_gecerli_i && r_bekleyen;
    assign w_ekle  = w_yanit && !r_dusur && !yrt_atlama_gecerli_i;
    assign w_ver   = w_hazir && !yrt_atlama_gecerli_i && !ddb_bosalt_i && !ddb_durdur_i;

    assign l1b_istek_gecerli_o = w_istek;
    assign l1b_adres_o         = r_ps_getir[30:1];

    getir_hizalayici #(
        .BASLANGIC_PS (BASLANGIC_PS[31:1])
    ) u_hizalayici (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .i_temizle    (yrt_atlama_gecerli_i),
        .i_temizle_ps (yrt_atlama_ps_i),
        .i_ekle       (w_ekle),
        .i_ekle_ust   (r_ust_yarim),
        .i_kelime     (l1b_buyruk_i),
        .i_tuket      (w_ver),
        .o_hazir      (w_hazir),
        .o_buyruk     (w_buyruk),
        .o_ps         (w_ps),
        .o_ps_sonraki (w_ps_sonraki),
        .o_sayi       (w_sayi)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ps_getir  <= BASLANGIC_PS[31:1];
            r_bekleyen  <= 1'b0;
            r_ust_yarim <= 1'b0;
            r_dusur     <= 1'b0;
        end else begin
            if (yrt_atlama_gecerli_i) begin
                r_ps_getir <= yrt_atlama_ps_i;
            end else if (w_kabul) begin
                r_ps_getir <= {r_ps_getir[30:1] + 30'd1, 1'b0};
            end

            if (w_kabul) begin
                r_bekleyen  <= 1'b1;
                r_ust_yarim <= r_ps_getir[0];
            end else if (w_yanit) begin
                r_bekleyen <= 1'b0;
            end

            // A response landing in the redirect cycle is already discarded, so it needs no drop.
            if (yrt_atlama_gecerli_i) begin
                r_dusur <= (r_bekleyen && !w_yanit) || w_kabul;
            end else if (w_yanit) begin
                r_dusur <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_buyruk    <= NOP_BUYRUK;
            r_ps        <= '0;
            r_ps_artmis <= '0;
            r_bos       <= 1'b1;
        end else if (yrt_atlama_gecerli_i || ddb_bosalt_i) begin
            r_buyruk <= NOP_BUYRUK;
            r_bos    <= 1'b1;
        end else if (ddb_durdur_i) begin
            r_buyruk <= r_buyruk;
        end else if (w_hazir) begin
            r_buyruk    <= w_buyruk;
            r_ps        <= w_ps;
            r_ps_artmis <= w_ps_sonraki;
            r_bos       <= 1'b0;
        end else begin
            r_buyruk <= NOP_BUYRUK;
            r_bos    <= 1'b1;
        end
    end

    assign gtr_buyruk_o    = r_buyruk;
    assign gtr_ps_o        = r_ps;
    assign gtr_ps_artmis_o = r_ps_artmis;
    assign ddb_getir_bos_o = r_bos;

endmodule

// File: tb/tb_getir.sv
// Bench for the fetch stage: randomised memory and hazard stimulus checked against
// an instruction-stream model that parses memory halfword by halfword.
module tb_getir;

    localparam logic [31:0] NOP     = 32'h0000_0013;
    localparam logic [30:0] BAS_PS  = 31'h2000_0000;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [29:0] l1b_adres_o;
    logic        l1b_istek_gecerli_o;
    logic        l1b_istek_hazir_i;
    logic [31:0] l1b_buyruk_i;
    logic        l1b_buyruk_gecerli_i;
    logic        yrt_atlama_gecerli_i;
    logic [30:0] yrt_atlama_ps_i;
    logic        ddb_durdur_i;
    logic        ddb_bosalt_i;
    logic [31:0] gtr_buyruk_o;
    logic [30:0] gtr_ps_o;
    logic [30:0] gtr_ps_artmis_o;
    logic        ddb_getir_bos_o;

    getir dut (
        .clk_i                (clk_i),
        .rst_i                (rst_i),
        .l1b_adres_o          (l1b_adres_o),
        .l1b_istek_gecerli_o  (l1b_istek_gecerli_o),
        .l1b_istek_hazir_i    (l1b_istek_hazir_i),
        .l1b_buyruk_i         (l1b_buyruk_i),
        .l1b_buyruk_gecerli_i (l1b_buyruk_gecerli_i),
        .yrt_atlama_gecerli_i (yrt_atlama_gecerli_i),
        .yrt_atlama_ps_i      (yrt_atlama_ps_i),
        .ddb_durdur_i         (ddb_durdur_i),
        .ddb_bosalt_i         (ddb_bosalt_i),
        .gtr_buyruk_o         (gtr_buyruk_o),
        .gtr_ps_o             (gtr_ps_o),
        .gtr_ps_artmis_o      (gtr_ps_artmis_o),
        .ddb_getir_bos_o      (ddb_getir_bos_o)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_err = 0;
    int n_issue = 0;
    int n_kabul = 0;

    logic [31:0] mem [256];
    int hazir_yuzde = 100;
    int gec_min = 1;
    int gec_max = 1;

    logic [30:0] m_pc;
    logic        son_verildi;
    logic [31:0] son_buy;
    logic [30:0] son_ps;
    logic [30:0] son_art;

    // Memory: one word per accept, returned after gec_min..gec_max cycles, in order.
    logic        mm_bek = 1'b0;
    int          mm_kalan = 0;
    logic [29:0] mm_adr = '0;
    initial begin
        l1b_istek_hazir_i    = 1'b0;
        l1b_buyruk_gecerli_i = 1'b0;
        l1b_buyruk_i         = '0;
        forever begin
            @(negedge clk_i);
            l1b_buyruk_gecerli_i = 1'b0;
            if (mm_bek) begin
                if (mm_kalan == 0) begin
                    l1b_buyruk_gecerli_i = 1'b1;
                    l1b_buyruk_i         = mem[mm_adr[7:0]];
                    mm_bek               = 1'b0;
                end else begin
                    mm_kalan--;
                end
            end
            l1b_istek_hazir_i = ($urandom_range(99) < hazir_yuzde);
            if (l1b_istek_gecerli_o && l1b_istek_hazir_i) begin
                mm_bek   = 1'b1;
                mm_adr   = l1b_adres_o;
                mm_kalan = $urandom_range(gec_max, gec_min) - 1;
                n_kabul++;
            end
        end
    end

    function automatic logic [15:0] m_yarim(input logic [30:0] pc);
        logic [31:0] w;
        w = mem[pc[8:1]];
        return pc[0] ? w[31:16] : w[15:0];
    endfunction

    // One clock; the outputs after the edge are checked against the stream model.
    task automatic adim();
        logic        p_rst, p_yrt, p_bosalt, p_durdur;
        logic [30:0] p_hedef;
        logic [31:0] e_buy;
        logic [30:0] e_ps, e_art;
        logic        e_bos;
        logic [15:0] h0, h1;
        logic [31:0] x_buy;
        logic [30:0] x_art;
        p_rst = rst_i; p_yrt = yrt_atlama_gecerli_i; p_hedef = yrt_atlama_ps_i;
        p_bosalt = ddb_bosalt_i; p_durdur = ddb_durdur_i;
        e_buy = gtr_buyruk_o; e_ps = gtr_ps_o; e_art = gtr_ps_artmis_o; e_bos = ddb_getir_bos_o;
        son_verildi = 1'b0;
        @(posedge clk_i);
        #2;
        n_cmp++;
        if (p_rst) begin
            m_pc = BAS_PS;
            if ({gtr_buyruk_o, gtr_ps_o, gtr_ps_artmis_o, ddb_getir_bos_o} !== {NOP, 31'h0, 31'h0, 1'b1}) begin
                n_err++;
                $display("FAIL reset_outputs: got buyruk=%h ps=%h artmis=%h bos=%b, want %h 0 0 1",
                         gtr_buyruk_o, gtr_ps_o, gtr_ps_artmis_o, ddb_getir_bos_o, NOP);
            end
        end else if (p_yrt || p_bosalt) begin
            if (p_yrt) m_pc = p_hedef;
            if ({gtr_buyruk_o, ddb_getir_bos_o} !== {NOP, 1'b1}) begin
                n_err++;
                $display("FAIL flush_nop: got buyruk=%h bos=%b, want %h 1", gtr_buyruk_o, ddb_getir_bos_o, NOP);
            end
        end else if (p_durdur) begin
            if ({gtr_buyruk_o, gtr_ps_o, gtr_ps_artmis_o, ddb_getir_bos_o} !== {e_buy, e_ps, e_art, e_bos}) begin
                n_err++;
                $display("FAIL stall_hold: got %h/%h/%h/%b, want %h/%h/%h/%b", gtr_buyruk_o, gtr_ps_o,
                         gtr_ps_artmis_o, ddb_getir_bos_o, e_buy, e_ps, e_art, e_bos);
            end
        end else if (ddb_getir_bos_o === 1'b0) begin
            h0 = m_yarim(m_pc);
            if (h0[1:0] != 2'b11) begin
                x_buy = {16'h0000, h0};
                x_art = m_pc + 31'd1;
            end else begin
                h1    = m_yarim(m_pc + 31'd1);
                x_buy = {h1, h0};
                x_art = m_pc + 31'd2;
            end
            if ({gtr_buyruk_o, gtr_ps_o, gtr_ps_artmis_o} !== {x_buy, m_pc, x_art}) begin
                n_err++;
                $display("FAIL issue: got buyruk=%h ps=%h artmis=%h, want %h %h %h",
                         gtr_buyruk_o, gtr_ps_o, gtr_ps_artmis_o, x_buy, m_pc, x_art);
            end
            m_pc = x_art;
            son_verildi = 1'b1;
            son_buy = gtr_buyruk_o; son_ps = gtr_ps_o; son_art = gtr_ps_artmis_o;
            n_issue++;
        end else begin
            if ({gtr_buyruk_o, gtr_ps_o, gtr_ps_artmis_o} !== {NOP, e_ps, e_art}) begin
                n_err++;
                $display("FAIL bubble: got buyruk=%h ps=%h artmis=%h, want %h %h %h",
                         gtr_buyruk_o, gtr_ps_o, gtr_ps_artmis_o, NOP, e_ps, e_art);
            end
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        adim();
        adim();
        n_cmp++;
        if (l1b_istek_gecerli_o !== 1'b0) begin
            n_err++;
            $display("FAIL reset_no_request: got %b, want 0", l1b_istek_gecerli_o);
        end
        rst_i = 1'b0;
        #1;
        n_cmp++;
        if ({l1b_istek_gecerli_o, l1b_adres_o} !== {1'b1, 30'h1000_0000}) begin
            n_err++;
            $display("FAIL first_request: got valid=%b adr=%h, want 1 10000000", l1b_istek_gecerli_o, l1b_adres_o);
        end
    endtask

    task automatic test_ilk_buyruk_ve_hizalama();
        logic [31:0] b [3];
        logic [30:0] p [3];
        logic [30:0] a [3];
        int k, d, ilk;
        k = 0; d = 0; ilk = 0;
        while (k < 3 && d < 30) begin
            adim();
            d++;
            if (son_verildi) begin
                b[k] = son_buy; p[k] = son_ps; a[k] = son_art;
                if (k == 0) ilk = d;
                k++;
            end
        end
        n_cmp++;
        if (k != 3) begin
            n_err++;
            $display("FAIL first_issues_timeout: got %0d issues, want 3", k);
        end else begin
            n_cmp += 4;
            if (ilk != 3) begin
                n_err++;
                $display("FAIL first_issue_latency: got cycle %0d, want 3", ilk);
            end
            if ({b[0], p[0], a[0]} !== {32'h00A0_0093, 31'h2000_0000, 31'h2000_0002}) begin
                n_err++;
                $display("FAIL first_instr: got %h %h %h, want 00a00093 20000000 20000002", b[0], p[0], a[0]);
            end
            if ({b[1], p[1], a[1]} !== {32'h0000_4505, 31'h2000_0002, 31'h2000_0003}) begin
                n_err++;
                $display("FAIL compressed_instr: got %h %h %h, want 00004505 20000002 20000003", b[1], p[1], a[1]);
            end
            if ({b[2], p[2], a[2]} !== {32'h0013_0013, 31'h2000_0003, 31'h2000_0005}) begin
                n_err++;
                $display("FAIL straddling_instr: got %h %h %h, want 00130013 20000003 20000005", b[2], p[2], a[2]);
            end
        end
    endtask

    task automatic test_yonlendirme();
        int d;
        d = 0;
        while (l1b_istek_gecerli_o !== 1'b1 && d < 20) begin adim(); d++; end
        yrt_atlama_gecerli_i = 1'b1;
        yrt_atlama_ps_i      = 31'h2000_0081;
        adim();
        yrt_atlama_gecerli_i = 1'b0;
        d = 0;
        while (l1b_istek_gecerli_o !== 1'b1 && d < 20) begin adim(); d++; end
        n_cmp++;
        if ({l1b_istek_gecerli_o, l1b_adres_o} !== {1'b1, 30'h1000_0040}) begin
            n_err++;
            $display("FAIL redirect_request: got valid=%b adr=%h, want 1 10000040", l1b_istek_gecerli_o, l1b_adres_o);
        end
        d = 0;
        son_verildi = 1'b0;
        while (!son_verildi && d < 20) begin adim(); d++; end
        n_cmp++;
        if ({son_verildi, son_buy, son_ps, son_art} !== {1'b1, 32'h0000_0001, 31'h2000_0081, 31'h2000_0082}) begin
            n_err++;
            $display("FAIL redirect_first_issue: got v=%b %h %h %h, want 1 00000001 20000081 20000082",
                     son_verildi, son_buy, son_ps, son_art);
        end
    endtask

    task automatic test_durdur();
        int n0, i0;
        logic [31:0] s_buy;
        logic [30:0] s_ps;
        repeat (3) adim();
        s_buy = gtr_buyruk_o; s_ps = gtr_ps_o;
        ddb_durdur_i = 1'b1;
        n0 = n_kabul;
        repeat (5) adim();
        ddb_durdur_i = 1'b0;
        n_cmp += 2;
        if ({gtr_buyruk_o, gtr_ps_o} !== {s_buy, s_ps}) begin
            n_err++;
            $display("FAIL stall_outputs: got %h %h, want %h %h", gtr_buyruk_o, gtr_ps_o, s_buy, s_ps);
        end
        if (n_kabul - n0 > 2) begin
            n_err++;
            $display("FAIL stall_accepts: got %0d, want at most 2", n_kabul - n0);
        end
        i0 = n_issue;
        repeat (20) adim();
        n_cmp++;
        if (n_issue - i0 < 5) begin
            n_err++;
            $display("FAIL stall_resume: got %0d issues, want at least 5", n_issue - i0);
        end
    endtask

    task automatic test_bosalt_durdur();
        int i0;
        repeat (4) adim();
        ddb_durdur_i = 1'b1;
        ddb_bosalt_i = 1'b1;
        adim();
        ddb_durdur_i = 1'b0;
        ddb_bosalt_i = 1'b0;
        n_cmp++;
        if ({gtr_buyruk_o, ddb_getir_bos_o} !== {32'h0000_0013, 1'b1}) begin
            n_err++;
            $display("FAIL flush_over_stall: got %h bos=%b, want 00000013 1", gtr_buyruk_o, ddb_getir_bos_o);
        end
        i0 = n_issue;
        repeat (15) adim();
        n_cmp++;
        if (n_issue - i0 < 3) begin
            n_err++;
            $display("FAIL flush_resume: got %0d issues, want at least 3", n_issue - i0);
        end
    endtask

    task automatic test_reset_bekleyen();
        int d;
        gec_min = 2; gec_max = 2;
        d = 0;
        while (l1b_istek_gecerli_o !== 1'b1 && d < 20) begin adim(); d++; end
        adim();
        rst_i = 1'b1;
        adim();
        rst_i = 1'b0;
        #1;
        n_cmp++;
        if ({l1b_istek_gecerli_o, l1b_adres_o} !== {1'b1, 30'h1000_0000}) begin
            n_err++;
            $display("FAIL reset_refetch: got valid=%b adr=%h, want 1 10000000", l1b_istek_gecerli_o, l1b_adres_o);
        end
        d = 0;
        son_verildi = 1'b0;
        while (!son_verildi && d < 30) begin adim(); d++; end
        n_cmp++;
        if ({son_verildi, son_buy, son_ps} !== {1'b1, 32'h00A0_0093, 31'h2000_0000}) begin
            n_err++;
            $display("FAIL reset_late_response: got v=%b %h %h, want 1 00a00093 20000000", son_verildi, son_buy, son_ps);
        end
        gec_min = 1; gec_max = 1;
    endtask

    task automatic test_rastgele();
        int i0;
        logic [30:0] t;
        hazir_yuzde = 70; gec_min = 1; gec_max = 3;
        i0 = n_issue;
        for (int c = 0; c < 1500; c++) begin
            ddb_durdur_i = ($urandom_range(99) < 20);
            ddb_bosalt_i = ($urandom_range(99) < 5);
            yrt_atlama_gecerli_i = ($urandom_range(99) < 3);
            if ($urandom_range(3) == 0) t = 31'h7FFF_FFF0 + 31'($urandom_range(15));
            else t = 31'($urandom);
            yrt_atlama_ps_i = t;
            adim();
        end
        ddb_durdur_i = 1'b0; ddb_bosalt_i = 1'b0; yrt_atlama_gecerli_i = 1'b0;
        repeat (20) adim();
        n_cmp++;
        if (n_issue - i0 < 100) begin
            n_err++;
            $display("FAIL random_progress: got %0d issues, want at least 100", n_issue - i0);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        mem[0]    = 32'h00A0_0093;
        mem[1]    = 32'h0013_4505;
        mem[2]    = 32'h0000_0013;
        mem[8'h40] = 32'h0001_0002;
        rst_i = 1'b1;
        yrt_atlama_gecerli_i = 1'b0;
        yrt_atlama_ps_i = '0;
        ddb_durdur_i = 1'b0;
        ddb_bosalt_i = 1'b0;
        m_pc = BAS_PS;
        test_reset();
        test_ilk_buyruk_ve_hizalama();
        test_yonlendirme();
        test_durdur();
        test_bosalt_durdur();
        test_reset_bekleyen();
        test_rastgele();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
